display_source_scheduler: RTL and testbench



---
 rtl/display_sched_pkg.sv | 32 +++
 rtl/dwell_timer.sv | 30 +++
 rtl/display_source_scheduler.sv | 106 ++++++++++
 tb/tb_display_source_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display source scheduler.
package display_sched_pkg;

    localparam int SEL_W = 2;
    localparam int N_SRC = 4;

    typedef enum logic {
        SWITCH = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // Next enabled source after cur, scanning cyclically. The last probe lands
    // back on cur, so a mask with only cur set returns cur. An empty mask also
    // returns cur.
    function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                      input logic [N_SRC-1:0] mask);
        logic [SEL_W-1:0] nxt;
        logic [SEL_W-1:0] idx;
        logic             found;
        nxt   = cur;
        found = 1'b0;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Up-counter with a synchronous clear and a one-cycle terminal flag.
// done is high on the enabled cycle whose count equals COUNT-1; the counter
// wraps to zero on that same edge.
module dwell_timer #(
    parameter int COUNT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int             CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

    logic [CNT_W-1:0] count;

    assign done = en && (count == LAST);

    // Count enabled cycles, wrapping after the terminal value; clear wins over enable
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_source_scheduler.sv
// Drives the 4-to-1 display mux select, waits for the mux to settle, then
// tracks the selected source in a registered display value. Auto mode rotates
// through enabled sources with a fixed dwell; manual mode follows sel_manual.
module display_source_scheduler
    import display_sched_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DWELL_CYCLES  = 50_000_000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_auto,
    input  logic [1:0]       sel_manual,
    input  logic [3:0]       enable_mask,
    input  logic [WIDTH-1:0] mux_out,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] display_value,
    output logic             display_valid,
    output logic             switch_pulse
);

    state_t           state;
    logic             manual_req;
    logic [SEL_W-1:0] auto_next;
    logic             settle_clr;
    logic             settle_en;
    logic             settle_done;
    logic             dwell_clr;
    logic             dwell_en;
    logic             dwell_done;

    // Manual mode retargets whenever the switches disagree with the current select
    assign manual_req = !mode_auto && (sel_manual != s);
    assign auto_next  = next_enabled(s, enable_mask);

    // Settle count runs only while switching and restarts on every select change
    assign settle_en  = (state == SWITCH);
    assign settle_clr = (state == HOLD) || manual_req;

    // Dwell count runs only while holding in auto mode; it sits at zero otherwise,
    // so entering auto mode always starts a full dwell
    assign dwell_en  = (state == HOLD) && mode_auto;
    assign dwell_clr = !dwell_en;

    dwell_timer #(
        .COUNT (SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .clr  (settle_clr),
        .en   (settle_en),
        .done (settle_done)
    );

    dwell_timer #(
        .COUNT (DWELL_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (dwell_clr),
        .en   (dwell_en),
        .done (dwell_done)
    );

    // Scheduler FSM: select register, display capture and switch pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SWITCH;
            s             <= '0;
            display_value <= '0;
            display_valid <= 1'b0;
            switch_pulse  <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            case (state)
                SWITCH: begin
                    if (manual_req) begin
                        s            <= sel_manual;
                        switch_pulse <= 1'b1;
                    end else if (settle_done) begin
                        state         <= HOLD;
                        display_value <= mux_out;
                        display_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    display_value <= mux_out;
                    if (manual_req) begin
                        s             <= sel_manual;
                        switch_pulse  <= 1'b1;
                        display_valid <= 1'b0;
                        state         <= SWITCH;
                    end else if (dwell_done && (auto_next != s)) begin
                        s             <= auto_next;
                        switch_pulse  <= 1'b1;
                        display_valid <= 1'b0;
                        state         <= SWITCH;
                    end
                end
                default: state <= SWITCH;
            endcase
        end
    end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: directed scenarios plus a random phase,
// with a cycle-level reference model feeding a scoreboard queue.
module tb_display_source_scheduler;

    localparam int WIDTH  = 16;
    localparam int DWELL  = 8;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_auto;
    logic [1:0]       sel_manual;
    logic [3:0]       enable_mask;
    logic [WIDTH-1:0] mux_out;
    logic [1:0]       s;
    logic [WIDTH-1:0] display_value;
    logic             display_valid;
    logic             switch_pulse;
    logic [WIDTH-1:0] in1, in2, in3, in4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // The external 4-to-1 mux
    assign mux_out = (s == 2'd0) ? in1 : (s == 2'd1) ? in2 : (s == 2'd2) ? in3 : in4;

    display_source_scheduler #(
        .WIDTH         (WIDTH),
        .DWELL_CYCLES  (DWELL),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_auto     (mode_auto),
        .sel_manual    (sel_manual),
        .enable_mask   (enable_mask),
        .mux_out       (mux_out),
        .s             (s),
        .display_value (display_value),
        .display_valid (display_valid),
        .switch_pulse  (switch_pulse)
    );

    typedef struct packed {
        logic [1:0]       s;
        logic [WIDTH-1:0] val;
        logic             valid;
        logic             pulse;
    } exp_t;

    exp_t expq[$];

    function automatic logic [WIDTH-1:0] src_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return in1;
            2'd1:    return in2;
            2'd2:    return in3;
            default: return in4;
        endcase
    endfunction

    // Rotate the mask past cur and take the lowest set bit; empty mask keeps cur
    function automatic logic [1:0] next_src(input logic [1:0] cur, input logic [3:0] mask);
        logic [7:0] two;
        int         idx;
        two = {mask, mask};
        for (int k = 0; k < 4; k++) begin
            idx = int'(cur) + 1 + k;
            if (two[idx]) return 2'(idx % 4);
        end
        return cur;
    endfunction

    // Reference model: advance one clock edge from the rules, push the expectation
    logic [1:0]       m_s;
    bit               m_hold;
    int               m_settle_left;
    int               m_dwell;
    logic [WIDTH-1:0] m_val;
    bit               m_valid;
    bit               m_pulse;

    initial forever begin
        exp_t       e;
        logic [1:0] nxt;
        @(posedge clk);
        if (rst) begin
            m_s = 2'd0; m_hold = 0; m_settle_left = SETTLE; m_dwell = 0;
            m_val = '0; m_valid = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (!m_hold) begin
                m_dwell = 0;
                if (!mode_auto && sel_manual != m_s) begin
                    m_s = sel_manual; m_pulse = 1; m_settle_left = SETTLE;
                end else begin
                    m_settle_left = m_settle_left - 1;
                    if (m_settle_left == 0) begin
                        m_hold = 1; m_val = src_val(m_s); m_valid = 1;
                    end
                end
            end else begin
                m_val = src_val(m_s);
                if (!mode_auto) begin
                    m_dwell = 0;
                    if (sel_manual != m_s) begin
                        m_s = sel_manual; m_pulse = 1; m_valid = 0; m_hold = 0;
                        m_settle_left = SETTLE;
                    end
                end else begin
                    m_dwell = m_dwell + 1;
                    if (m_dwell == DWELL) begin
                        m_dwell = 0;
                        nxt = next_src(m_s, enable_mask);
                        if (nxt != m_s) begin
                            m_s = nxt; m_pulse = 1; m_valid = 0; m_hold = 0;
                            m_settle_left = SETTLE;
                        end
                    end
                end
            end
        end
        e.s = m_s; e.val = m_val; e.valid = m_valid; e.pulse = m_pulse;
        expq.push_back(e);
    end

    // Monitor: every cycle the DUT presents registered outputs; compare on the falling edge
    initial forever begin
        exp_t e;
        @(negedge clk);
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL sb_empty t=%0t: no expectation queued", $time);
        end else begin
            e = expq.pop_front();
            if ({s, display_value, display_valid, switch_pulse} !== e) begin
                miscompares++;
                $display("FAIL sb_cycle t=%0t got s=%0d val=%h valid=%b pulse=%b, want s=%0d val=%h valid=%b pulse=%b",
                         $time, s, display_value, display_valid, switch_pulse,
                         e.s, e.val, e.valid, e.pulse);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int         pulses;
        int         nonzero;
        logic [7:0] seqv;

        rst = 1'b1; mode_auto = 1'b1; sel_manual = 2'd0; enable_mask = 4'hF;
        in1 = 16'hA5A5; in2 = 16'h5A5A; in3 = 16'hFFFF; in4 = 16'h0F0F;

        // Auto, all sources enabled
        do_reset();
        chk("rst_s", 32'(s), 0);
        chk("rst_valid", 32'(display_valid), 0);
        tick(2);
        chk("auto_first_val", 32'(display_value), 'hA5A5);
        chk("auto_first_valid", 32'(display_valid), 1);
        tick(7);
        chk("auto_dwell_hold_s", 32'(s), 0);
        tick(1);
        chk("auto_adv_s", 32'(s), 1);
        chk("auto_adv_pulse", 32'(switch_pulse), 1);
        chk("auto_adv_valid", 32'(display_valid), 0);
        tick(2);
        chk("auto_adv_val", 32'(display_value), 'h5A5A);
        chk("auto_adv_valid2", 32'(display_valid), 1);

        // Auto, mask 1010: 00 shown until dwell, then 01, 11, 01, 11
        enable_mask = 4'b1010;
        do_reset();
        pulses = 0; seqv = '0;
        for (int n = 0; n < 41; n++) begin
            tick(1);
            if (switch_pulse) begin
                pulses++;
                seqv = {seqv[5:0], s};
            end
        end
        chk("mask1010_pulses", 32'(pulses), 4);
        chk("mask1010_seq", 32'(seqv), 'b01_11_01_11);

        // Auto, empty mask: select never moves, display keeps tracking
        enable_mask = 4'b0000;
        do_reset();
        pulses = 0; nonzero = 0;
        for (int n = 0; n < 40; n++) begin
            tick(1);
            if (switch_pulse) pulses++;
            if (s != 2'd0) nonzero++;
        end
        chk("mask0_pulses", 32'(pulses), 0);
        chk("mask0_s_moved", 32'(nonzero), 0);
        in1 = 16'h5A5A;
        tick(1);
        chk("mask0_track", 32'(display_value), 'h5A5A);
        in1 = 16'hA5A5;
        tick(1);

        // Manual, back-to-back retarget during SWITCH
        mode_auto = 1'b0; sel_manual = 2'd0; enable_mask = 4'hF;
        do_reset();
        tick(3);
        sel_manual = 2'd2;
        tick(1);
        chk("man_s10", 32'(s), 2);
        chk("man_s10_pulse", 32'(switch_pulse), 1);
        sel_manual = 2'd3;
        tick(1);
        chk("man_s11", 32'(s), 3);
        chk("man_s11_pulse", 32'(switch_pulse), 1);
        tick(1);
        chk("man_settle_restart", 32'(display_valid), 0);
        tick(1);
        chk("man_cap_valid", 32'(display_valid), 1);
        chk("man_cap_val", 32'(display_value), 'h0F0F);

        // Reset mid-SWITCH with s=11
        sel_manual = 2'd0;
        tick(4);
        sel_manual = 2'd3;
        tick(1);
        chk("midsw_s", 32'(s), 3);
        rst = 1'b1;
        tick(1);
        chk("midrst_s", 32'(s), 0);
        chk("midrst_val", 32'(display_value), 0);
        chk("midrst_valid", 32'(display_valid), 0);
        chk("midrst_pulse", 32'(switch_pulse), 0);

        // Manual -> auto at s=10: full dwell before first advance
        sel_manual = 2'd2;
        rst = 1'b0;
        tick(5);
        chk("m2a_pre_s", 32'(s), 2);
        mode_auto = 1'b1;
        tick(7);
        chk("m2a_hold_s", 32'(s), 2);
        tick(1);
        chk("m2a_adv_s", 32'(s), 3);
        chk("m2a_adv_pulse", 32'(switch_pulse), 1);

        // Random phase, checked by the scoreboard every cycle
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
            if ($urandom_range(0, 7) == 0) sel_manual = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) enable_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0:       in1 = 16'($urandom);
                    1:       in2 = 16'($urandom);
                    2:       in3 = 16'($urandom);
                    default: in4 = 16'($urandom);
                endcase
            end
            tick(1);
        end
        rst = 1'b0;
        tick(1);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
